// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the PC / return-address stack sequencing back end.
// Default sizes and the FSM state encoding used by pc_stack_unit.
package pc_stack_unit_pkg;

    // Default sizing: 5-bit program counter, 8-entry return stack.
    localparam int PC_WIDTH_DEF    = 5;
    localparam int STACK_DEPTH_DEF = 8;
    localparam int SP_WIDTH_DEF    = 3;

    // Sequencer FSM: RUN executes commands, HALT freezes everything until rst.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

endpackage : pc_stack_unit_pkg

// File: rtl/pc_stack_unit_ret_addr_stack.sv
// LIFO storage for return addresses. The caller guarantees that push and
// pop are never asserted together. Push is ignored when full and pop is
// ignored when empty, so the occupancy count cannot wrap. Storage entries are
// never reset; top reads 0 while the stack is empty, so stale data stays hidden.
module ret_addr_stack
    import pc_stack_unit_pkg::*;
#(
    parameter int DATA_WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH      = STACK_DEPTH_DEF,
    parameter int SP_WIDTH   = SP_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] top,
    output logic [SP_WIDTH:0]     depth,
    output logic                  full,
    output logic                  empty
);

    localparam logic [SP_WIDTH:0] FULL_CNT = (SP_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [SP_WIDTH:0]     depth_q;
    logic [SP_WIDTH-1:0]   wr_idx;
    logic [SP_WIDTH-1:0]   top_idx;
    logic                  do_push;
    logic                  do_pop;

    // Status and addressing derived only from the registered count.
    always_comb begin
        full    = (depth_q == FULL_CNT);
        empty   = (depth_q == '0);
        wr_idx  = depth_q[SP_WIDTH-1:0];
        top_idx = depth_q[SP_WIDTH-1:0] - SP_WIDTH'(1);
        do_push = push && !full;
        do_pop  = pop && !empty;
        depth   = depth_q;
        top     = empty ? '0 : mem[top_idx];
    end

    // Occupancy counter; the only stack state that reset touches.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + (SP_WIDTH+1)'(1);
        end else if (do_pop) begin
            depth_q <= depth_q - (SP_WIDTH+1)'(1);
        end
    end

    // Entry storage: written on push, contents otherwise held.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_idx] <= data_in;
        end
    end

endmodule : ret_addr_stack

// File: rtl/pc_stack_unit.sv
// Program counter and call/return sequencing. Resolves the jmp/cal/ret
// command priority (ret > cal > jmp), drives the return-address stack,
// records sticky error flags and halts on stack overflow/underflow.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int SP_WIDTH    = SP_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                jmp,
    input  logic                cal,
    input  logic                ret,
    input  logic [PC_WIDTH-1:0] jmp_addr,
    output logic [PC_WIDTH-1:0] instr_addr,
    output logic [PC_WIDTH-1:0] ret_addr,
    output logic [SP_WIDTH:0]   depth,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                halted,
    output logic                overflow_err,
    output logic                underflow_err,
    output logic                multi_cmd_err
);

    seq_state_t          state_q, state_n;
    logic [PC_WIDTH-1:0] pc_q, pc_n;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                ovf_q, ovf_n;
    logic                unf_q, unf_n;
    logic                multi_q, multi_n;
    logic                push;
    logic                pop;
    logic                multi_cmd;
    logic [PC_WIDTH-1:0] stk_top;
    logic [SP_WIDTH:0]   stk_depth;
    logic                stk_full;
    logic                stk_empty;

    ret_addr_stack #(
        .DATA_WIDTH (PC_WIDTH),
        .DEPTH      (STACK_DEPTH),
        .SP_WIDTH   (SP_WIDTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .data_in (pc_inc),
        .top     (stk_top),
        .depth   (stk_depth),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    // Next-state, next-PC, stack control and error capture.
    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        ovf_n     = ovf_q;
        unf_n     = unf_q;
        multi_n   = multi_q;
        push      = 1'b0;
        pop       = 1'b0;
        // Increment wraps modulo 2^PC_WIDTH; also the pushed return address.
        pc_inc    = pc_q + PC_WIDTH'(1);
        multi_cmd = (jmp && cal) || (jmp && ret) || (cal && ret);

        if (state_q == ST_RUN && !stall) begin
            if (multi_cmd) begin
                multi_n = 1'b1;
            end
            if (ret) begin
                if (stk_empty) begin
                    unf_n   = 1'b1;
                    state_n = ST_HALT;
                end else begin
                    pop  = 1'b1;
                    pc_n = stk_top;
                end
            end else if (cal) begin
                if (stk_full) begin
                    ovf_n   = 1'b1;
                    state_n = ST_HALT;
                end else begin
                    push = 1'b1;
                    pc_n = jmp_addr;
                end
            end else if (jmp) begin
                pc_n = jmp_addr;
            end else begin
                pc_n = pc_inc;
            end
        end
    end

    // Control registers; reset overrides stall and HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
            multi_q <= multi_n;
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        instr_addr    = pc_q;
        ret_addr      = stk_top;
        depth         = stk_depth;
        stack_full    = stk_full;
        stack_empty   = stk_empty;
        halted        = (state_q == ST_HALT);
        overflow_err  = ovf_q;
        underflow_err = unf_q;
        multi_cmd_err = multi_q;
    end

endmodule : pc_stack_unit

// File: tb/tb_pc_stack_unit.sv
// Directed testbench for pc_stack_unit with hand-computed expectations.
module tb_pc_stack_unit;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       jmp;
    logic       cal;
    logic       ret;
    logic [4:0] jmp_addr;
    logic [4:0] instr_addr;
    logic [4:0] ret_addr;
    logic [3:0] depth;
    logic       stack_full;
    logic       stack_empty;
    logic       halted;
    logic       overflow_err;
    logic       underflow_err;
    logic       multi_cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    pc_stack_unit #(
        .PC_WIDTH    (5),
        .STACK_DEPTH (8),
        .SP_WIDTH    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jmp           (jmp),
        .cal           (cal),
        .ret           (ret),
        .jmp_addr      (jmp_addr),
        .instr_addr    (instr_addr),
        .ret_addr      (ret_addr),
        .depth         (depth),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .halted        (halted),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .multi_cmd_err (multi_cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic j, input logic c, input logic r, input int addr);
        jmp      = j;
        cal      = c;
        ret      = r;
        jmp_addr = 5'(addr);
    endtask

    task automatic idle();
        set_cmd(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int pc, input int dep,
                             input int ra, input int hlt);
        chk({tag, ".pc"}, int'(instr_addr), pc);
        chk({tag, ".depth"}, int'(depth), dep);
        chk({tag, ".ret_addr"}, int'(ret_addr), ra);
        chk({tag, ".halted"}, int'(halted), hlt);
    endtask

    task automatic chk_errs(input string tag, input int ovf, input int unf, input int mul);
        chk({tag, ".ovf"}, int'(overflow_err), ovf);
        chk({tag, ".unf"}, int'(underflow_err), unf);
        chk({tag, ".multi"}, int'(multi_cmd_err), mul);
    endtask

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        idle();
        #2;

        // Reset state and free-running increment
        do_reset();
        chk_state("rst", 0, 0, 0, 0);
        chk("rst.empty", int'(stack_empty), 1);
        chk("rst.full", int'(stack_full), 0);
        chk_errs("rst", 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("inc.pc", int'(instr_addr), i);
        end

        // jmp at PC=4, then stall (commands under stall are ignored)
        set_cmd(1'b1, 1'b0, 1'b0, 20);
        step();
        chk("jmp.pc", int'(instr_addr), 20);
        idle();
        step();
        chk("jmp_inc.pc", int'(instr_addr), 21);
        stall = 1'b1;
        set_cmd(1'b1, 1'b1, 1'b1, 3);
        step();
        chk_state("stall1", 21, 0, 0, 0);
        step();
        chk_state("stall2", 21, 0, 0, 0);
        chk_errs("stall", 0, 0, 0);
        stall = 1'b0;
        idle();

        // Nested call / return
        do_reset();
        for (int i = 0; i < 6; i++) step();
        chk("pre_cal.pc", int'(instr_addr), 6);
        set_cmd(1'b0, 1'b1, 1'b0, 15);
        step();
        chk_state("cal1", 15, 1, 7, 0);
        idle();
        step();
        chk("cal1_inc.pc", int'(instr_addr), 16);
        set_cmd(1'b0, 1'b1, 1'b0, 2);
        step();
        chk_state("cal2", 2, 2, 17, 0);
        set_cmd(1'b0, 1'b0, 1'b1, 0);
        step();
        chk_state("ret1", 17, 1, 7, 0);
        step();
        chk_state("ret2", 7, 0, 0, 0);
        chk("ret2.empty", int'(stack_empty), 1);
        idle();

        // Fill the stack: cal at PC=i pushes i+1; eighth lands at PC=9
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_cmd(1'b0, 1'b1, 1'b0, (i == 7) ? 9 : i + 1);
            step();
        end
        chk_state("fill", 9, 8, 8, 0);
        chk("fill.full", int'(stack_full), 1);
        chk("fill.empty", int'(stack_empty), 0);
        set_cmd(1'b0, 1'b1, 1'b0, 25);
        step();
        chk_state("ovf", 9, 8, 8, 1);
        chk_errs("ovf", 1, 0, 0);
        set_cmd(1'b0, 1'b0, 1'b1, 0);
        step();
        set_cmd(1'b1, 1'b0, 1'b0, 4);
        step();
        idle();
        step();
        chk_state("halt_frozen", 9, 8, 8, 1);
        chk_errs("halt_frozen", 1, 0, 0);
        do_reset();
        chk_state("halt_rst", 0, 0, 0, 0);
        chk_errs("halt_rst", 0, 0, 0);

        // Underflow: ret on empty stack at PC=3
        for (int i = 0; i < 3; i++) step();
        set_cmd(1'b0, 1'b0, 1'b1, 0);
        step();
        chk_state("unf", 3, 0, 0, 1);
        chk_errs("unf", 0, 1, 0);
        idle();
        step();
        chk("unf_frozen.pc", int'(instr_addr), 3);

        // jmp+ret with one entry (top=12): ret wins, sticky multi, no halt
        do_reset();
        set_cmd(1'b1, 1'b0, 1'b0, 11);
        step();
        set_cmd(1'b0, 1'b1, 1'b0, 0);
        step();
        chk_state("pre_multi", 0, 1, 12, 0);
        set_cmd(1'b1, 1'b0, 1'b1, 5);
        step();
        chk_state("multi", 12, 0, 0, 0);
        chk_errs("multi", 0, 0, 1);
        idle();
        step();
        chk("multi_inc.pc", int'(instr_addr), 13);
        chk("multi_sticky", int'(multi_cmd_err), 1);

        // cal+jmp: cal wins over jmp
        set_cmd(1'b1, 1'b1, 1'b0, 22);
        step();
        chk_state("caljmp", 22, 1, 14, 0);
        idle();

        // PC wraparound and call from PC=31 pushing 0
        do_reset();
        set_cmd(1'b1, 1'b0, 1'b0, 31);
        step();
        idle();
        step();
        chk("wrap.pc", int'(instr_addr), 0);
        set_cmd(1'b1, 1'b0, 1'b0, 31);
        step();
        set_cmd(1'b0, 1'b1, 1'b0, 4);
        step();
        chk_state("cal31", 4, 1, 0, 0);
        set_cmd(1'b0, 1'b0, 1'b1, 0);
        step();
        chk_state("ret31", 0, 0, 0, 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_stack_unit
